// File: rtl/lmfe_win_ctrl_if.sv
// Column stream interface between the window source and lmfe_win_ctrl.
// Carries one WIN-pixel column per handshake plus the one-cycle FLUSH request.
interface lmfe_win_ctrl_if #(
    parameter int WIN = 7,
    parameter int DW  = 8
) ();
    logic              COL_VLD;
    logic [WIN*DW-1:0] COL_DAT;
    logic              COL_RDY;
    logic              FLUSH;

    modport master (
        output COL_VLD,
        output COL_DAT,
        output FLUSH,
        input  COL_RDY
    );

    modport slave (
        input  COL_VLD,
        input  COL_DAT,
        input  FLUSH,
        output COL_RDY
    );
endinterface

// File: rtl/lmfe_win_ctrl.sv
// lmfe_win_ctrl: window controller in front of the 49-entry insert/delete
// median engine. Keeps a WIN-column pixel history and, for every accepted
// column, replays WIN insert/delete pairs into the engine before capturing
// the engine median. FLUSH drains every held pixel back to all-ones.
// Optional macro LMFE_WIN_PROTO_CHK_EN adds a sticky PROTO_ERR output that
// flags column-handshake and FLUSH misuse by the upstream source.
module lmfe_win_ctrl #(
    parameter int WIN = 7,
    parameter int DW  = 8
) (
    input  logic           clk,
    input  logic           RST,
    lmfe_win_ctrl_if.slave col,
    output logic           SEN,
    output logic [DW-1:0]  INS,
    output logic [DW-1:0]  DEL,
    input  logic [DW-1:0]  MED_IN,
    output logic [DW-1:0]  MED_OUT,
    output logic           MED_VLD,
    output logic           BUSY
`ifdef LMFE_WIN_PROTO_CHK_EN
    ,
    output logic           PROTO_ERR
`endif
);

    localparam int IW = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int CW = $clog2(WIN + 1);
    localparam logic [DW-1:0] EMPTY = {DW{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        UPD,
        WAIT,
        FLSH
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_cnt_q, col_cnt_d;
    logic [IW-1:0] wr_ptr_q, wr_ptr_d;
    logic [IW-1:0] k_q, k_d;
    logic [IW-1:0] slot_q, slot_d;
    logic          flush_pend_q, flush_pend_d;
    logic [DW-1:0] med_out_q, med_out_d;
    logic          med_vld_q, med_vld_d;

    logic [DW-1:0] hist_q [WIN][WIN];
    logic [DW-1:0] stage_q [WIN];

    logic flush_req;
    logic accept;
    logic row_last;
    logic slot_last;
    logic win_full;

    assign flush_req   = col.FLUSH || flush_pend_q;
    assign col.COL_RDY = (state_q == IDLE) && !flush_pend_q && !col.FLUSH && !RST;
    assign accept      = col.COL_VLD && col.COL_RDY;
    assign row_last    = (k_q == IW'(WIN - 1));
    assign slot_last   = (slot_q == IW'(col_cnt_q - 1'b1));
    assign win_full    = (col_cnt_q == CW'(WIN));

    // State register; reset returns the controller to IDLE.
    always_ff @(posedge clk) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state selection: flush requests outrank new columns in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = (col_cnt_q != '0) ? FLSH : IDLE;
                end else if (accept) begin
                    state_d = UPD;
                end
            end
            UPD:     if (row_last) state_d = WAIT;
            WAIT:    state_d = IDLE;
            FLSH:    if (row_last && slot_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Engine drive: SEN low only while a real insert/delete pair is presented.
    always_comb begin
        SEN = 1'b1;
        INS = EMPTY;
        DEL = EMPTY;
        case (state_q)
            UPD: begin
                SEN = 1'b0;
                INS = stage_q[k_q];
                DEL = win_full ? hist_q[wr_ptr_q][k_q] : EMPTY;
            end
            FLSH: begin
                SEN = 1'b0;
                INS = EMPTY;
                DEL = hist_q[slot_q][k_q];
            end
            default: ;
        endcase
    end

    // Counter and median next values; a flush only clears the pending flag once drained.
    always_comb begin
        col_cnt_d    = col_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        k_d          = k_q;
        slot_d       = slot_q;
        med_out_d    = med_out_q;
        med_vld_d    = 1'b0;
        flush_pend_d = flush_pend_q || (col.FLUSH && (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    if (col_cnt_q == '0) flush_pend_d = 1'b0;
                    k_d    = '0;
                    slot_d = '0;
                end else if (accept) begin
                    k_d = '0;
                end
            end
            UPD: begin
                if (row_last) begin
                    k_d       = '0;
                    wr_ptr_d  = (wr_ptr_q == IW'(WIN - 1)) ? '0 : wr_ptr_q + 1'b1;
                    col_cnt_d = win_full ? col_cnt_q : col_cnt_q + 1'b1;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            WAIT: begin
                med_out_d = MED_IN;
                med_vld_d = win_full;
            end
            FLSH: begin
                if (row_last && slot_last) begin
                    col_cnt_d    = '0;
                    wr_ptr_d     = '0;
                    k_d          = '0;
                    slot_d       = '0;
                    flush_pend_d = 1'b0;
                end else if (row_last) begin
                    k_d    = '0;
                    slot_d = slot_q + 1'b1;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (RST) begin
            col_cnt_q    <= '0;
            wr_ptr_q     <= '0;
            k_q          <= '0;
            slot_q       <= '0;
            flush_pend_q <= 1'b0;
            med_out_q    <= '0;
            med_vld_q    <= 1'b0;
        end else begin
            col_cnt_q    <= col_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            k_q          <= k_d;
            slot_q       <= slot_d;
            flush_pend_q <= flush_pend_d;
            med_out_q    <= med_out_d;
            med_vld_q    <= med_vld_d;
        end
    end

    // Pixel storage: staging on accept, history overwritten row by row during UPD.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < WIN; r++) begin
                stage_q[r] <= col.COL_DAT[r*DW +: DW];
            end
        end
        if (!RST && (state_q == UPD)) begin
            hist_q[wr_ptr_q][k_q] <= stage_q[k_q];
        end
    end

    assign MED_OUT = med_out_q;
    assign MED_VLD = med_vld_q;
    assign BUSY    = (state_q != IDLE);

`ifdef LMFE_WIN_PROTO_CHK_EN
    logic              prev_vld_q;
    logic              prev_rdy_q;
    logic [WIN*DW-1:0] prev_dat_q;
    logic              proto_err_q;
    logic              proto_err_d;

    // A stalled column must stay valid and stable; FLUSH must not stack on a pending one.
    always_comb begin
        proto_err_d = proto_err_q
                    || (prev_vld_q && !prev_rdy_q
                        && (!col.COL_VLD || (col.COL_DAT != prev_dat_q)))
                    || (col.FLUSH && flush_pend_q);
    end

    // Previous-cycle handshake snapshot and the sticky error flag.
    always_ff @(posedge clk) begin
        if (RST) begin
            prev_vld_q  <= 1'b0;
            prev_rdy_q  <= 1'b0;
            prev_dat_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            prev_vld_q  <= col.COL_VLD;
            prev_rdy_q  <= col.COL_RDY;
            prev_dat_q  <= col.COL_DAT;
            proto_err_q <= proto_err_d;
        end
    end

    assign PROTO_ERR = proto_err_q;
`endif

endmodule
